// File: rtl/hpdl_pkg.sv
// rtl/hpdl_pkg.sv - shared types, constants and character mapping for the HPDL-1414 writer
package hpdl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    CLR_NEXT
  } state_t;

  localparam logic [6:0] CHAR_SPACE      = 7'h20;
  localparam logic [6:0] CHAR_MIN        = 7'h20;
  localparam logic [6:0] CHAR_MAX        = 7'h5F;
  localparam int         DIGITS_PER_DISP = 4;

  // Control codes blank out; lowercase folds onto the uppercase glyphs.
  function automatic logic [6:0] sanitize_char(input logic [6:0] c);
    if (c < CHAR_MIN) return CHAR_SPACE;
    if (c > CHAR_MAX) return c - 7'h20;
    return c;
  endfunction

endpackage

// File: rtl/hpdl_char_sanitize.sv
// rtl/hpdl_char_sanitize.sv - combinational map of ASCII codes into the displayable range
module hpdl_char_sanitize
  import hpdl_pkg::*;
#(
  parameter int SANITIZE = 1
) (
  input  logic [6:0] in_char,
  output logic [6:0] out_char
);

  assign out_char = (SANITIZE != 0) ? sanitize_char(in_char) : in_char;

endmodule

// File: rtl/hpdl1414_writer.sv
// rtl/hpdl1414_writer.sv - timed write controller for a chain of HPDL-1414 displays
module hpdl1414_writer
  import hpdl_pkg::*;
#(
  parameter int NUM_DISPLAYS = 4,
  parameter int POS_W        = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int SANITIZE     = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [POS_W-1:0]        in_pos,
  input  logic [6:0]              in_char,
  input  logic                    clear_req,
  output logic                    busy,
  output logic [6:0]              HPDL_D,
  output logic [1:0]              HPDL_A,
  output logic [NUM_DISPLAYS-1:0] HPDL_WR_N
);

  localparam int PH_MAX   = (SETUP_CYCLES > PULSE_CYCLES)
                            ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                            : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int LAST_POS = DIGITS_PER_DISP * NUM_DISPLAYS - 1;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [POS_W-1:0]        pos;
  logic                    clear_pending;
  logic                    clearing;
  logic [6:0]              clean_char;
  logic [NUM_DISPLAYS-1:0] strobe_n;

  hpdl_char_sanitize #(.SANITIZE(SANITIZE)) u_sanitize (
    .in_char (in_char),
    .out_char(clean_char)
  );

  assign HPDL_A = pos[1:0];
  assign busy   = (state != IDLE) || clear_pending;

  // An out-of-range display index leaves every strobe high but keeps the full timing.
  always_comb begin
    strobe_n = '1;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      if (32'(pos[POS_W-1:2]) == i) strobe_n[i] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      cnt           <= '0;
      pos           <= '0;
      HPDL_D        <= '0;
      HPDL_WR_N     <= '1;
      in_ready      <= 1'b0;
      clear_pending <= 1'b0;
      clearing      <= 1'b0;
    end else begin
      clear_pending <= clear_pending | clear_req;
      in_ready      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            pos    <= in_pos;
            HPDL_D <= clean_char;
            cnt    <= CNT_W'(SETUP_CYCLES - 1);
            state  <= SETUP;
          end else if (clear_pending) begin
            // Requests arriving as the clear starts merge into it.
            pos           <= '0;
            HPDL_D        <= CHAR_SPACE;
            clearing      <= 1'b1;
            clear_pending <= 1'b0;
            cnt           <= CNT_W'(SETUP_CYCLES - 1);
            state         <= SETUP;
          end else begin
            in_ready <= !clear_req;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            HPDL_WR_N <= strobe_n;
            cnt       <= CNT_W'(PULSE_CYCLES - 1);
            state     <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            HPDL_WR_N <= '1;
            cnt       <= CNT_W'(HOLD_CYCLES - 1);
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            if (clearing && (32'(pos) != LAST_POS)) begin
              state <= CLR_NEXT;
            end else begin
              clearing <= 1'b0;
              in_ready <= !(clear_pending || clear_req);
              state    <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CLR_NEXT: begin
          pos   <= pos + 1'b1;
          cnt   <= CNT_W'(SETUP_CYCLES - 1);
          state <= SETUP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
